pixel_compositor: RTL and testbench

- Downstream stage of the picture/sprite blob generators; drives the VGA output pins.
- Merges a background pixel and a sprite pixel using a transparency key, forces black during blanking, and applies a frame-stepped global fade.
- Delays the timing generator's hsync/vsync/blank to match the blobs' pixel latency, so sync and colour leave aligned.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/sync_delay.sv | 27 ++
 rtl/pixel_compositor.sv | 150 +++++++++++++++
 tb/tb_pixel_compositor.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA pixel types, fade constants and the per-channel fade helper.
package vga_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam int unsigned LEVEL_W = 5;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 5'd16;
  localparam logic [11:0] KEY_COLOR_DEFAULT = 12'h000;

  typedef enum logic [0:0] {StIdle, StFading} fade_state_e;

  // (c * level) >> 4; level 16 is identity, 0 is black.
  function automatic logic [3:0] fade_chan(input logic [3:0] c, input logic [LEVEL_W-1:0] level);
    logic [8:0] prod;
    prod = {5'b0, c} * {4'b0, level};
    return prod[7:4];
  endfunction

endpackage

// File: rtl/sync_delay.sv
// Reset-to-constant shift register used to align timing signals with pixel data.
module sync_delay #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift one stage per clock; reset fills every stage with RESET_VAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/pixel_compositor.sv
// Sprite/background merge with colour-key transparency, blanking and frame-stepped fade.
// Optional checkerboard test pattern when PIXEL_COMPOSITOR_TESTPAT_EN is defined.
module pixel_compositor
  import vga_pkg::*;
#(
  parameter int unsigned PIX_LAT = 2,
  parameter logic [11:0] KEY_COLOR = KEY_COLOR_DEFAULT,
  parameter int unsigned FRAMES_PER_STEP = 4
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blank_in,
  input  logic [11:0] bg_pixel_in,
  input  logic [11:0] sprite_pixel_in,
  input  logic        fade_start_in,
  input  logic        fade_dir_in,
`ifdef PIXEL_COMPOSITOR_TESTPAT_EN
  input  logic        test_pat_in,
`endif
  output logic        hs_out,
  output logic        vs_out,
  output logic [11:0] rgb_out,
  output logic        fade_busy_out
);

  localparam logic [7:0] STEP_LAST = 8'(FRAMES_PER_STEP - 1);

  logic [2:0]         dly_sync;
  logic               dly_hs, dly_vs, dly_blank;
  logic               frame_tick;
  fade_state_e        state_q;
  logic [LEVEL_W-1:0] level_q, target_q, level_step, fade_target;
  logic [7:0]         frame_cnt_q;
  rgb12_t             px;

  sync_delay #(
    .DEPTH    (PIX_LAT),
    .WIDTH    (3),
    .RESET_VAL(3'b111)
  ) u_sync_delay (
    .clk(pixel_clk_in),
    .rst(rst_in),
    .d  ({hsync_in, vsync_in, blank_in}),
    .q  (dly_sync)
  );

  assign dly_hs    = dly_sync[2];
  assign dly_vs    = dly_sync[1];
  assign dly_blank = dly_sync[0];

  // vs_out holds the previous delayed vsync, so this fires once per frame start.
  assign frame_tick  = vs_out & ~dly_vs;
  assign fade_target = fade_dir_in ? LEVEL_MAX : '0;

  // One level toward the target; holding when equal keeps the level inside 0..16.
  always_comb begin
    level_step = level_q;
    if (target_q > level_q)      level_step = level_q + 1'b1;
    else if (target_q < level_q) level_step = level_q - 1'b1;
  end

  // Output register stage for the aligned syncs.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      hs_out <= 1'b1;
      vs_out <= 1'b1;
    end else begin
      hs_out <= dly_hs;
      vs_out <= dly_vs;
    end
  end

  // Fade FSM: start pulses are honoured only while idle; level steps on frame ticks.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= StIdle;
      level_q       <= LEVEL_MAX;
      target_q      <= LEVEL_MAX;
      frame_cnt_q   <= '0;
      fade_busy_out <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (fade_start_in && (fade_target != level_q)) begin
            target_q      <= fade_target;
            frame_cnt_q   <= '0;
            fade_busy_out <= 1'b1;
            state_q       <= StFading;
          end
        end
        StFading: begin
          if (frame_tick) begin
            if (frame_cnt_q == STEP_LAST) begin
              frame_cnt_q <= '0;
              level_q     <= level_step;
              if (level_step == target_q) begin
                state_q       <= StIdle;
                fade_busy_out <= 1'b0;
              end
            end else begin
              frame_cnt_q <= frame_cnt_q + 8'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef PIXEL_COMPOSITOR_TESTPAT_EN
  logic [9:0] hcount_q, vcount_q;
  logic       blank_prev_q;

  // Pixel/line counters in the delayed timing domain; lines advance at end of active video.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      hcount_q     <= '0;
      vcount_q     <= '0;
      blank_prev_q <= 1'b1;
    end else begin
      blank_prev_q <= dly_blank;
      hcount_q     <= dly_blank ? 10'd0 : hcount_q + 10'd1;
      if (!dly_vs)                        vcount_q <= '0;
      else if (dly_blank && !blank_prev_q) vcount_q <= vcount_q + 10'd1;
    end
  end
`endif

  // Colour-key select, optionally overridden by the 8x8 checkerboard.
  always_comb begin
    px = (sprite_pixel_in == KEY_COLOR) ? bg_pixel_in : sprite_pixel_in;
`ifdef PIXEL_COMPOSITOR_TESTPAT_EN
    if (test_pat_in) px = (hcount_q[3] ^ vcount_q[3]) ? 12'h000 : 12'hFFF;
`endif
  end

  // Registered colour: black in blanking, otherwise faded by the current level.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      rgb_out <= '0;
    end else if (dly_blank) begin
      rgb_out <= '0;
    end else begin
      rgb_out <= {fade_chan(px.r, level_q), fade_chan(px.g, level_q), fade_chan(px.b, level_q)};
    end
  end

endmodule

// File: tb/tb_pixel_compositor.sv
// Randomised scoreboard bench for pixel_compositor against a frame-level fade model.
module tb_pixel_compositor;

  localparam int unsigned PIX_LAT = 2;
  localparam int unsigned FPS     = 2;
  localparam logic [11:0] KEY     = 12'h000;
  localparam int          LINE_W  = 24;
  localparam int          FRAME_H = 6;

  logic        clk = 1'b0;
  logic        rst, hsync, vsync, blank, fade_start, fade_dir;
  logic [11:0] bg, sprite;
  logic        hs_out, vs_out, fade_busy;
  logic [11:0] rgb_out;
`ifdef PIXEL_COMPOSITOR_TESTPAT_EN
  logic        test_pat = 1'b0;
`endif

  always #5 clk = ~clk;

  pixel_compositor #(
    .PIX_LAT        (PIX_LAT),
    .KEY_COLOR      (KEY),
    .FRAMES_PER_STEP(FPS)
  ) dut (
    .pixel_clk_in   (clk),
    .rst_in         (rst),
    .hsync_in       (hsync),
    .vsync_in       (vsync),
    .blank_in       (blank),
    .bg_pixel_in    (bg),
    .sprite_pixel_in(sprite),
    .fade_start_in  (fade_start),
    .fade_dir_in    (fade_dir),
`ifdef PIXEL_COMPOSITOR_TESTPAT_EN
    .test_pat_in    (test_pat),
`endif
    .hs_out         (hs_out),
    .vs_out         (vs_out),
    .rgb_out        (rgb_out),
    .fade_busy_out  (fade_busy)
  );

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  bit h_hist[16], v_hist[16], b_hist[16];
  int cyc = 16;
  int m_level, m_target, m_start, m_ticks;
  bit m_fading;
  int tg_x = 0, tg_y = 0;

  function automatic int fade(input int c, input int level);
    return (c * level) / 16;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      h_hist[i] = 1'b1;
      v_hist[i] = 1'b1;
      b_hist[i] = 1'b1;
    end
    m_level  = 16;
    m_fading = 1'b0;
    m_ticks  = 0;
  endtask

  // Drive one cycle at the falling edge and queue what the next rising edge must produce.
  task automatic drive_cycle(input bit r, input bit h, input bit v, input bit b,
                             input logic [11:0] bgv, input logic [11:0] spv,
                             input bit st, input bit dir);
    exp_t e;
    int   idx, d, p, tgt, steps;
    logic [11:0] px;
    bit   tick;
    @(negedge clk);
    rst = r; hsync = h; vsync = v; blank = b;
    bg = bgv; sprite = spv; fade_start = st; fade_dir = dir;
    if (r) begin
      model_reset();
      e = '{hs: 1'b1, vs: 1'b1, rgb: 12'h000, busy: 1'b0};
    end else begin
      idx = cyc & 15;
      d   = (cyc - PIX_LAT) & 15;
      p   = (cyc - PIX_LAT - 1) & 15;
      h_hist[idx] = h; v_hist[idx] = v; b_hist[idx] = b;
      px = (spv == KEY) ? bgv : spv;
      e.hs  = h_hist[d];
      e.vs  = v_hist[d];
      e.rgb = b_hist[d] ? 12'h000 :
              12'((fade(int'(px[11:8]), m_level) << 8) |
                  (fade(int'(px[7:4]), m_level) << 4) | fade(int'(px[3:0]), m_level));
      tick = v_hist[p] && !v_hist[d];
      if (!m_fading) begin
        if (st) begin
          tgt = dir ? 16 : 0;
          if (tgt != m_level) begin
            m_fading = 1'b1;
            m_target = tgt;
            m_start  = m_level;
            m_ticks  = 0;
          end
        end
      end else if (tick) begin
        m_ticks++;
        steps   = m_ticks / FPS;
        m_level = (m_target > m_start) ? m_start + steps : m_start - steps;
        if (m_level == m_target) m_fading = 1'b0;
      end
      e.busy = m_fading;
    end
    cyc++;
    exp_q.push_back(e);
  endtask

  // Runs the timing generator; mode 0 random pixels, mode 1 white background with keyed sprite.
  task automatic run_cycles(input int n, input int start_at, input bit dir, input int mode,
                            input bit extra_starts);
    bit h, v, b, st;
    logic [11:0] bgv, spv;
    for (int i = 0; i < n; i++) begin
      b = (tg_x >= 16) || (tg_y >= FRAME_H - 1);
      h = !((tg_x >= 18) && (tg_x < 22));
      v = (tg_y != FRAME_H - 1);
      if (mode == 1) begin
        bgv = 12'hFFF;
        spv = KEY;
      end else begin
        bgv = 12'($urandom);
        spv = ($urandom_range(0, 1) == 0) ? KEY : 12'($urandom);
      end
      st = (i == start_at) || (extra_starts && ($urandom_range(0, 199) == 0));
      drive_cycle(1'b0, h, v, b, bgv, spv, st, dir);
      tg_x++;
      if (tg_x == LINE_W) begin
        tg_x = 0;
        tg_y = (tg_y + 1) % FRAME_H;
      end
    end
  endtask

  // Monitor: compare each rising-edge result with the scoreboard head.
  initial begin
    exp_t e, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = '{hs: hs_out, vs: vs_out, rgb: rgb_out, busy: fade_busy};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got hs=%b vs=%b rgb=%h busy=%b expected hs=%b vs=%b rgb=%h busy=%b",
                   $time, got.hs, got.vs, got.rgb, got.busy, e.hs, e.vs, e.rgb, e.busy);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; hsync = 1'b1; vsync = 1'b1; blank = 1'b1;
    bg = '0; sprite = '0; fade_start = 1'b0; fade_dir = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, 12'h000, 12'h000, 1'b0, 1'b0);
    // Idle, then directed keyed / opaque sprite pixels and a lone hsync drop.
    for (int i = 0; i < 6; i++) drive_cycle(1'b0, 1'b1, 1'b1, 1'b1, 12'hFFF, 12'h000, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 12'hABC, 12'h000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 12'hABC, 12'h000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 12'hABC, 12'h5A0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, 1'b1, 1'b1, 12'hFFF, 12'h000, 1'b0, 1'b0);
    run_cycles(300, -1, 1'b0, 0, 1'b0);
    // Full fade-out on a white field, with stray start pulses while fading.
    run_cycles(LINE_W * FRAME_H * 34, 10, 1'b0, 1, 1'b1);
    // Already at zero: fade-out request must not assert busy.
    run_cycles(300, 5, 1'b0, 0, 1'b0);
    // Fade-in interrupted by reset after several ticks.
    run_cycles(LINE_W * FRAME_H * 6 + 20, 5, 1'b1, 0, 1'b0);
    for (int i = 0; i < 2; i++) drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, 12'h123, 12'h456, 1'b0, 1'b0);
    run_cycles(300, 5, 1'b1, 0, 1'b0);
    run_cycles(LINE_W * FRAME_H * 5, 3, 1'b0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
